// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, with sign correction in a final FIX cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             r_state;
  logic               r_div;
  logic               r_sa;
  logic               r_sb;
  logic               r_dz;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_add;
  logic [WIDTH-1:0]   r_raw_a;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

  // Magnitudes only for signed ops (Op[0] set)
  assign w_mag_a = (Op[0] && OperandA[WIDTH-1]) ? -OperandA : OperandA;
  assign w_mag_b = (Op[0] && OperandB[WIDTH-1]) ? -OperandB : OperandB;

  // Multiply: {upper, multiplier}; add multiplicand on LSB, shift right
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + {1'b0, (r_acc[0] ? r_add : {WIDTH{1'b0}})};
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: {remainder, quotient}; shift left, trial subtract
  assign w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff   = w_rem_sh - {1'b0, r_add};
  assign w_div_nxt = w_diff[WIDTH]
                   ? {r_acc[2*WIDTH-2:0], 1'b0}
                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = (r_sa ^ r_sb) ? -r_acc : r_acc;
  assign w_q    = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_r    = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_div     <= 1'b0;
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
      r_dz      <= 1'b0;
      r_cnt     <= '0;
      r_add     <= '0;
      r_raw_a   <= '0;
      r_acc     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      Done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (Start) begin
            r_div     <= Op[1];
            r_sa      <= Op[0] & OperandA[WIDTH-1];
            r_sb      <= Op[0] & OperandB[WIDTH-1];
            r_dz      <= Op[1] & (OperandB == '0);
            r_raw_a   <= OperandA;
            r_add     <= Op[1] ? w_mag_b : w_mag_a;
            r_acc     <= {{WIDTH{1'b0}}, (Op[1] ? w_mag_a : w_mag_b)};
            r_cnt     <= '0;
            Busy      <= 1'b1;
            DivByZero <= 1'b0;
            r_state   <= CALC;
          end
        end
        CALC: begin
          r_acc <= r_div ? w_div_nxt : w_mul_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1))
            r_state <= FIX;
        end
        FIX: begin
          if (r_div) begin
            HI <= r_dz ? r_raw_a : w_r;
            LO <= r_dz ? {WIDTH{1'b1}} : w_q;
          end else begin
            {HI, LO} <= w_prod;
          end
          DivByZero <= r_dz;
          Done      <= 1'b1;
          Busy      <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed + randomized bench for mult_div_unit with a result scoreboard.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] OperandA;
  logic [W-1:0] OperandB;
  logic         Busy;
  logic         Done;
  logic         DivByZero;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  always #5 Clock = ~Clock;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .HI(HI), .LO(LO)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi,
                        input logic [W-1:0] elo, input logic edz,
                        input bit push);
    exp_t e;
    Start = 1'b1;
    Op = op;
    OperandA = a;
    OperandB = b;
    if (push) begin
      e.hi = ehi;
      e.lo = elo;
      e.dz = edz;
      sb.push_back(e);
    end
    step(1);
    Start = 1'b0;
    OperandA = $urandom;
    OperandB = $urandom;
    Op = 2'($urandom);
  endtask

  task automatic wait_done(input string tag, output int cyc,
                           output int bcnt);
    exp_t e;
    cyc = 0;
    bcnt = 0;
    while (!Done && cyc < 100) begin
      if (Busy) bcnt++;
      step(1);
      cyc++;
    end
    chk({tag, "_done_seen"}, 64'(Done), 64'd1);
    if (Done) begin
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk({tag, "_hi"}, 64'(HI), 64'(e.hi));
        chk({tag, "_lo"}, 64'(LO), 64'(e.lo));
        chk({tag, "_dz"}, 64'(DivByZero), 64'(e.dz));
      end
    end
  endtask

  function automatic exp_t model(input logic [1:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic [63:0] p;
    p = '0;
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      2'd0: p = {32'b0, a} * {32'b0, b};
      2'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      2'd2: begin
        e.lo = a / b;
        e.hi = a % b;
      end
      default: begin
        e.lo = $signed(a) / $signed(b);
        e.hi = $signed(a) % $signed(b);
      end
    endcase
    if (!op[1]) begin
      e.hi = p[63:32];
      e.lo = p[31:0];
    end
    return e;
  endfunction

  initial begin
    int cyc;
    int bc;
    int dn;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    exp_t e;

    Reset = 1'b1;
    Start = 1'b0;
    Op = 2'd0;
    OperandA = '0;
    OperandB = '0;
    step(3);
    chk("rst_hi", 64'(HI), 64'd0);
    chk("rst_lo", 64'(LO), 64'd0);
    chk("rst_busy", 64'(Busy), 64'd0);
    chk("rst_done", 64'(Done), 64'd0);
    chk("rst_dz", 64'(DivByZero), 64'd0);
    Reset = 1'b0;
    step(1);

    launch(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
           32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b1);
    wait_done("multu_max", cyc, bc);
    chk("multu_latency", 64'(cyc), 64'd33);
    chk("multu_busy_cycles", 64'(bc), 64'd33);
    chk("multu_busy_at_done", 64'(Busy), 64'd0);
    step(1);
    chk("done_single_pulse", 64'(Done), 64'd0);
    chk("hi_hold", 64'(HI), 64'hFFFFFFFE);

    launch(2'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b1);
    wait_done("mult_neg", cyc, bc);
    launch(2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b1);
    wait_done("div_neg", cyc, bc);

    launch(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    wait_done("divu_100_7", cyc, bc);
    launch(2'd2, 32'h1234, 32'd0, 32'h1234, 32'hFFFFFFFF, 1'b1, 1'b1);
    wait_done("divu_zero", cyc, bc);
    chk("divu_zero_latency", 64'(cyc), 64'd33);
    step(3);
    chk("dz_sticky", 64'(DivByZero), 64'd1);
    launch(2'd0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 1'b1);
    chk("dz_clear_on_start", 64'(DivByZero), 64'd0);
    wait_done("multu_2_3", cyc, bc);

    launch(2'd3, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1'b1);
    wait_done("div_zero_signed", cyc, bc);

    launch(2'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 1'b1);
    wait_done("div_ovf", cyc, bc);

    launch(2'd2, 32'd50, 32'd5, 32'd0, 32'd10, 1'b0, 1'b1);
    step(9);
    Start = 1'b1;
    Op = 2'd0;
    OperandA = 32'd3;
    OperandB = 32'd3;
    step(1);
    Start = 1'b0;
    chk("busy_ignore_start", 64'(Busy), 64'd1);
    wait_done("divu_50_5", cyc, bc);
    launch(2'd0, 32'd3, 32'd3, 32'd0, 32'd9, 1'b0, 1'b1);
    chk("b2b_done_cleared", 64'(Done), 64'd0);
    chk("b2b_busy", 64'(Busy), 64'd1);
    wait_done("multu_b2b", cyc, bc);
    chk("b2b_latency", 64'(cyc), 64'd33);
    step(1);
    chk("no_extra_result", 64'(sb.size()), 64'd0);

    launch(2'd0, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    step(14);
    Reset = 1'b1;
    step(1);
    Reset = 1'b0;
    chk("abort_busy", 64'(Busy), 64'd0);
    chk("abort_hi", 64'(HI), 64'd0);
    chk("abort_lo", 64'(LO), 64'd0);
    dn = 0;
    repeat (40) begin
      if (Done) dn++;
      step(1);
    end
    chk("abort_no_done", 64'(dn), 64'd0);
    launch(2'd0, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b1);
    wait_done("multu_6_7", cyc, bc);

    for (int i = 0; i < 8; i++) begin
      op = 2'(i % 4);
      a = $urandom;
      b = $urandom;
      if (op[1] && (i % 8) >= 4) b = $urandom_range(1, 1000);
      if (op[1] && b == '0) b = 32'd1;
      if (op == 2'd3 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      e = model(op, a, b);
      launch(op, a, b, e.hi, e.lo, e.dz, 1'b1);
      wait_done("rand", cyc, bc);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the EX stage, directly downstream of the register file.
- Consumes ReadData1 (as OperandA) and ReadData2 (as OperandB) for MULT, MULTU, DIV and DIVU.
- Produces the MIPS HI/LO pair using a radix-2 shift-add / restoring-divide datapath with a Start/Busy/Done handshake.
- The stall/forwarding logic holds the pipeline on Busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- OperandA  input  WIDTH  multiplicand / dividend (register file ReadData1).
- OperandB  input  WIDTH  multiplier / divisor (register file ReadData2).
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- DivByZero  output  1  sticky flag for the last operation: divide with OperandB==0.
- HI  output  WIDTH  multiply upper half / divide remainder.
- LO  output  WIDTH  multiply lower half / divide quotient.

Behaviour:
- Reset (sampled at a rising edge) forces the following, including mid-operation, which aborts with no result written:
  - state = IDLE
  - HI = 0, LO = 0
  - Busy = 0, Done = 0, DivByZero = 0
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - Start=1 at edge k: capture Op, sign flags and the magnitudes of both operands. Magnitudes are taken only for signed ops; otherwise the raw operand is used.
  - Clear the iteration counter, go to CALC. Busy=1 from after edge k.
  - Start=0: stay in IDLE. Done is low except for the pulse below.
- CALC: exactly WIDTH iterations, one per edge, at edges k+1 .. k+WIDTH, then go to FIX.
  - Multiply: 2*WIDTH-bit shift-add. Examine the multiplier LSB, conditionally add the multiplicand into the upper half, shift right by 1.
  - Divide: restoring divide. Shift {remainder, quotient} left by 1, trial-subtract the divisor; if non-negative, keep the result and set quotient bit 0.
- FIX (edge k+WIDTH+1):
  - Apply sign correction and write HI/LO. Set Done=1 and Busy=0, return to IDLE.
  - Done is high for exactly the cycle after edge k+WIDTH+1 and clears at the next edge.
  - Total latency from the Start cycle to the Done cycle is WIDTH+2 edges.
- Sign rules:
  - MULT: negate the 2*WIDTH product if the operand signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
  - MULTU/DIVU: no correction.
- Divide by zero (OperandB==0 at capture, DIVU or DIV):
  - Still takes the full latency.
  - Result: LO = all ones, HI = OperandA as captured (original signed value for DIV).
  - DivByZero=1 together with Done; it stays set until the next accepted Start, which clears it.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, no flag.
- Start while Busy: ignored; no queuing, operands not resampled.
- Start in the same cycle as Done: accepted, because the state is already IDLE. The new operation begins and Done still pulses for the old one.
- Operand changes after capture have no effect.
- HI/LO hold their value between operations and change only in FIX or on Reset.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF * 0xFFFFFFFF → Busy high for 33 cycles; Done pulses once, 34 edges after Start; HI=0xFFFFFFFE, LO=0x00000001.
- MULT 0xFFFFFFFD (-3) * 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV 0xFFFFFFF9 (-7) / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 7 → LO=0x0000000E, HI=0x00000002, DivByZero=0. Then DIVU 0x1234 / 0 → LO=0xFFFFFFFF, HI=0x00001234, DivByZero=1; the next Start clears DivByZero.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0, DivByZero=0.
- Start DIVU 50/5, pulse Start with MULTU 3*3 at cycle 10 while Busy → that Start is ignored; result LO=10, HI=0; Start asserted in the Done cycle launches a new operation.
- Start MULTU 6*7, assert Reset at cycle 15 → next cycle Busy=0, HI=LO=0, and no Done pulse follows. A subsequent MULTU 6*7 gives LO=42, HI=0.
